// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared state encoding and RAM word field constants for the quiz round controller
package quiz_pkg;

    // Round controller states
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] FETCH   = 4'd1;
    localparam logic [3:0] WAIT_RD = 4'd2;
    localparam logic [3:0] CAPTURE = 4'd3;
    localparam logic [3:0] SHOW    = 4'd4;
    localparam logic [3:0] JUDGE   = 4'd5;
    localparam logic [3:0] FB_OK   = 4'd6;
    localparam logic [3:0] FB_BAD  = 4'd7;
    localparam logic [3:0] SETTLE  = 4'd8;
    localparam logic [3:0] OVER    = 4'd9;

    // The expected answer index occupies the top ANS_W bits of a RAM word,
    // the glyph code fills the rest.
    localparam int ANS_W   = 2;
    localparam int ADDR_W  = 2;
    localparam int SCORE_W = 8;
    localparam int LIVES_W = 3;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'hFF;

endpackage

// File: rtl/quiz_round_ctrl_fb_timer.sv
// rtl/quiz_round_ctrl_fb_timer.sv - loadable down-counter with done flag for feedback and settle waits
module fb_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load of N keeps done low for N-1 cycles; done marks the last cycle of the wait.
    assign done_o = (cnt_q <= CNT_W'(1));

    // Next count: clear wins over load, load wins over counting down.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// rtl/quiz_round_ctrl.sv - fetches a question, shows it, judges answers and keeps score and lives
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int FB_CYCLES     = 50000000,
    parameter int SETTLE_CYCLES = 4,
    parameter int START_LIVES   = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [ADDR_W-1:0]       rand_addr_i,
    output logic [ADDR_W-1:0]       ram_addr_o,
    output logic                    ram_rd_en_o,
    input  logic [DATA_W-1:0]       ram_data_i,
    input  logic                    answer_valid_i,
    input  logic [ANS_W-1:0]        answer_i,
    output logic [DATA_W-ANS_W-1:0] disp_glyph_o,
    output logic                    disp_valid_o,
    output logic                    force_change_o,
    output logic                    correct_led_o,
    output logic                    wrong_led_o,
    output logic [SCORE_W-1:0]      score_o,
    output logic [LIVES_W-1:0]      lives_o,
    output logic                    game_over_o
);

    localparam int GLY_W = DATA_W - ANS_W;
    localparam int MAXC  = (FB_CYCLES > SETTLE_CYCLES) ? FB_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    logic [3:0]         state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic               ram_rd_en_q, ram_rd_en_d;
    logic [ANS_W-1:0]   exp_ans_q, exp_ans_d;
    logic [ANS_W-1:0]   ans_q, ans_d;
    logic [GLY_W-1:0]   glyph_q, glyph_d;
    logic               disp_valid_q, disp_valid_d;
    logic               force_change_q, force_change_d;
    logic               correct_led_q, correct_led_d;
    logic               wrong_led_q, wrong_led_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               game_over_q, game_over_d;

    logic               tmr_clr;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_val;
    logic               tmr_done;

    fb_timer #(
        .CNT_W(CNT_W)
    ) u_fb_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .done_o     (tmr_done)
    );

    // Round sequencing: next state, datapath updates and timer control.
    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        ram_addr_d     = ram_addr_q;
        ram_rd_en_d    = 1'b0;
        exp_ans_d      = exp_ans_q;
        ans_d          = ans_q;
        glyph_d        = glyph_q;
        disp_valid_d   = disp_valid_q;
        force_change_d = 1'b0;
        correct_led_d  = correct_led_q;
        wrong_led_d    = wrong_led_q;
        score_d        = score_q;
        lives_d        = lives_q;
        game_over_d    = game_over_q;
        tmr_clr        = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_val   = CNT_W'(FB_CYCLES);

        if (state_q != OVER && !enable_i) begin
            // Leaving the game pauses it: feedback and display drop, score and lives stay.
            state_d       = IDLE;
            disp_valid_d  = 1'b0;
            correct_led_d = 1'b0;
            wrong_led_d   = 1'b0;
            tmr_clr       = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    cur_addr_d  = rand_addr_i;
                    ram_addr_d  = rand_addr_i;
                    ram_rd_en_d = 1'b1;
                    state_d     = WAIT_RD;
                end
                WAIT_RD: begin
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    exp_ans_d    = ram_data_i[DATA_W-1 -: ANS_W];
                    glyph_d      = ram_data_i[GLY_W-1:0];
                    disp_valid_d = 1'b1;
                    state_d      = SHOW;
                end
                SHOW: begin
                    // An answer beats a question rotation arriving in the same cycle.
                    if (answer_valid_i) begin
                        ans_d   = answer_i;
                        state_d = JUDGE;
                    end else if (rand_addr_i != cur_addr_q) begin
                        state_d = FETCH;
                    end
                end
                JUDGE: begin
                    tmr_load = 1'b1;
                    if (ans_q == exp_ans_q) begin
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        correct_led_d = 1'b1;
                        state_d       = FB_OK;
                    end else begin
                        if (lives_q != '0) begin
                            lives_d = lives_q - LIVES_W'(1);
                        end
                        wrong_led_d = 1'b1;
                        state_d     = FB_BAD;
                    end
                end
                FB_OK: begin
                    if (tmr_done) begin
                        correct_led_d  = 1'b0;
                        force_change_d = 1'b1;
                        disp_valid_d   = 1'b0;
                        tmr_load       = 1'b1;
                        tmr_load_val   = CNT_W'(SETTLE_CYCLES);
                        state_d        = SETTLE;
                    end
                end
                SETTLE: begin
                    // Give the address stage time to publish the new address.
                    if (tmr_done) begin
                        state_d = FETCH;
                    end
                end
                FB_BAD: begin
                    if (tmr_done) begin
                        wrong_led_d = 1'b0;
                        if (lives_q == '0) begin
                            game_over_d  = 1'b1;
                            disp_valid_d = 1'b0;
                            state_d      = OVER;
                        end else begin
                            state_d = SHOW;
                        end
                    end
                end
                OVER: begin
                    game_over_d  = 1'b1;
                    disp_valid_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cur_addr_q     <= '0;
            ram_addr_q     <= '0;
            ram_rd_en_q    <= 1'b0;
            exp_ans_q      <= '0;
            ans_q          <= '0;
            glyph_q        <= '0;
            disp_valid_q   <= 1'b0;
            force_change_q <= 1'b0;
            correct_led_q  <= 1'b0;
            wrong_led_q    <= 1'b0;
            score_q        <= '0;
            lives_q        <= LIVES_W'(START_LIVES);
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_addr_q     <= cur_addr_d;
            ram_addr_q     <= ram_addr_d;
            ram_rd_en_q    <= ram_rd_en_d;
            exp_ans_q      <= exp_ans_d;
            ans_q          <= ans_d;
            glyph_q        <= glyph_d;
            disp_valid_q   <= disp_valid_d;
            force_change_q <= force_change_d;
            correct_led_q  <= correct_led_d;
            wrong_led_q    <= wrong_led_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            game_over_q    <= game_over_d;
        end
    end

    assign ram_addr_o     = ram_addr_q;
    assign ram_rd_en_o    = ram_rd_en_q;
    assign disp_glyph_o   = glyph_q;
    assign disp_valid_o   = disp_valid_q;
    assign force_change_o = force_change_q;
    assign correct_led_o  = correct_led_q;
    assign wrong_led_o    = wrong_led_q;
    assign score_o        = score_q;
    assign lives_o        = lives_q;
    assign game_over_o    = game_over_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb/tb_quiz_round_ctrl.sv - directed self-checking bench for quiz_round_ctrl
module tb_quiz_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] rand_addr;
    logic [1:0] ram_addr;
    logic       ram_rd_en;
    logic [7:0] ram_data = 8'h00;
    logic       answer_valid;
    logic [1:0] answer;
    logic [5:0] disp_glyph;
    logic       disp_valid;
    logic       force_change;
    logic       correct_led;
    logic       wrong_led;
    logic [7:0] score;
    logic [2:0] lives;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:3];

    always #5 clk = ~clk;

    // Character RAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (ram_rd_en) ram_data <= mem[ram_addr];
    end

    quiz_round_ctrl #(
        .DATA_W(8), .FB_CYCLES(4), .SETTLE_CYCLES(2), .START_LIVES(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .rand_addr_i(rand_addr),
        .ram_addr_o(ram_addr), .ram_rd_en_o(ram_rd_en), .ram_data_i(ram_data),
        .answer_valid_i(answer_valid), .answer_i(answer),
        .disp_glyph_o(disp_glyph), .disp_valid_o(disp_valid),
        .force_change_o(force_change), .correct_led_o(correct_led),
        .wrong_led_o(wrong_led), .score_o(score), .lives_o(lives),
        .game_over_o(game_over)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; answer_valid = 1'b0; answer = 2'd0; rand_addr = 2'd0;
        steps(2);
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", lives); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
        checks++;
        if ({disp_valid, ram_rd_en, force_change, correct_led, wrong_led, game_over} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b want 000000",
                {disp_valid, ram_rd_en, force_change, correct_led, wrong_led, game_over});
        end
        checks++; if (ram_addr !== 2'd0) begin errors++; $display("FAIL reset_ram_addr got %0d want 0", ram_addr); end
        rst = 1'b0;
        steps(2);
        checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL idle_no_read got %b want 0", ram_rd_en); end
    endtask

    task automatic test_fetch();
        rand_addr = 2'd2; enable = 1'b1;
        steps(2);
        checks++; if (ram_rd_en !== 1'b1) begin errors++; $display("FAIL fetch_rd_en got %b want 1", ram_rd_en); end
        checks++; if (ram_addr !== 2'd2) begin errors++; $display("FAIL fetch_addr got %0d want 2", ram_addr); end
        step();
        checks++; if ({ram_rd_en, disp_valid} !== 2'b00) begin errors++; $display("FAIL fetch_capture got %b want 00", {ram_rd_en, disp_valid}); end
        step();
        checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL fetch_disp_valid got %b want 1", disp_valid); end
        checks++; if (disp_glyph !== 6'h03) begin errors++; $display("FAIL fetch_glyph got %h want 03", disp_glyph); end
        checks++; if ({score, lives} !== {8'd0, 3'd3}) begin errors++; $display("FAIL fetch_score_lives got %0d/%0d want 0/3", score, lives); end
    endtask

    task automatic test_timeout();
        int rd_cnt = 0;
        for (int i = 0; i < 3; i++) begin step(); rd_cnt += int'(ram_rd_en); end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL show_hold reads got %0d want 0", rd_cnt); end
        rand_addr = 2'd3;
        steps(2);
        checks++; if ({ram_rd_en, ram_addr} !== 3'b1_11) begin errors++; $display("FAIL timeout_fetch got %b want 111", {ram_rd_en, ram_addr}); end
        steps(2);
        checks++; if ({disp_valid, disp_glyph} !== {1'b1, 6'h04}) begin errors++; $display("FAIL timeout_glyph got %b/%h want 1/04", disp_valid, disp_glyph); end
        checks++; if ({score, lives} !== {8'd0, 3'd3}) begin errors++; $display("FAIL timeout_score_lives got %0d/%0d want 0/3", score, lives); end
    endtask

    task automatic test_correct();
        int led_cnt = 0;
        int fc_cnt  = 0;
        rand_addr = 2'd0;
        steps(4);
        checks++; if ({disp_valid, disp_glyph} !== {1'b1, 6'h01}) begin errors++; $display("FAIL correct_q_glyph got %b/%h want 1/01", disp_valid, disp_glyph); end
        answer = 2'd2; answer_valid = 1'b1;
        step();
        answer_valid = 1'b0;
        step();
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL correct_score got %0d want 1", score); end
        led_cnt += int'(correct_led); fc_cnt += int'(force_change);
        for (int i = 3; i <= 9; i++) begin
            step();
            led_cnt += int'(correct_led); fc_cnt += int'(force_change);
            if (i == 6) begin
                checks++; if ({force_change, disp_valid} !== 2'b10) begin errors++; $display("FAIL correct_fc_edge got %b want 10", {force_change, disp_valid}); end
            end
            if (i == 8) begin
                checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL settle_len early read got %b want 0", ram_rd_en); end
            end
            if (i == 9) begin
                checks++; if ({ram_rd_en, ram_addr} !== 3'b1_00) begin errors++; $display("FAIL correct_refetch got %b want 100", {ram_rd_en, ram_addr}); end
            end
        end
        checks++; if (led_cnt != 4) begin errors++; $display("FAIL correct_led_len got %0d want 4", led_cnt); end
        checks++; if (fc_cnt != 1) begin errors++; $display("FAIL correct_fc_count got %0d want 1", fc_cnt); end
        steps(2);
        checks++; if ({disp_valid, disp_glyph} !== {1'b1, 6'h01}) begin errors++; $display("FAIL correct_reshow got %b/%h want 1/01", disp_valid, disp_glyph); end
    endtask

    task automatic test_back_to_back();
        answer = 2'd2; answer_valid = 1'b1; rand_addr = 2'd1;
        step();
        answer_valid = 1'b0;
        step();
        checks++; if ({correct_led, wrong_led, score} !== {2'b10, 8'd2}) begin errors++; $display("FAIL same_cycle_judge got %b%b/%0d want 10/2", correct_led, wrong_led, score); end
        steps(7);
        checks++; if ({ram_rd_en, ram_addr} !== 3'b1_01) begin errors++; $display("FAIL same_cycle_fetch got %b want 101", {ram_rd_en, ram_addr}); end
        steps(2);
        checks++; if (disp_glyph !== 6'h02) begin errors++; $display("FAIL same_cycle_glyph got %h want 02", disp_glyph); end
    endtask

    task automatic test_wrong();
        int act = 0;
        answer = 2'd0;
        for (int k = 0; k < 3; k++) begin
            answer_valid = 1'b1;
            step();
            answer_valid = 1'b0;
            step();
            checks++; if ({wrong_led, lives} !== {1'b1, 3'(2 - k)}) begin errors++; $display("FAIL wrong_%0d led/lives got %b/%0d want 1/%0d", k, wrong_led, lives, 2 - k); end
            steps(4);
            checks++;
            if ({wrong_led, game_over, disp_valid} !== ((k < 2) ? 3'b001 : 3'b010)) begin
                errors++; $display("FAIL wrong_%0d end led/over/valid got %b want %b", k,
                    {wrong_led, game_over, disp_valid}, (k < 2) ? 3'b001 : 3'b010);
            end
        end
        answer = 2'd1;
        for (int i = 0; i < 8; i++) begin
            answer_valid = i[0];
            enable = ~i[1];
            step();
            act += int'(ram_rd_en) + int'(correct_led) + int'(wrong_led) + int'(disp_valid);
        end
        answer_valid = 1'b0; enable = 1'b1;
        checks++; if (act != 0) begin errors++; $display("FAIL over_activity got %0d want 0", act); end
        checks++; if ({game_over, lives, score} !== {1'b1, 3'd0, 8'd2}) begin errors++; $display("FAIL over_hold got %b/%0d/%0d want 1/0/2", game_over, lives, score); end
    endtask

    task automatic test_enable_drop();
        int fc_cnt = 0;
        rst = 1'b1; rand_addr = 2'd0; enable = 1'b1;
        step();
        rst = 1'b0;
        steps(4);
        checks++; if ({game_over, disp_valid, disp_glyph} !== {2'b01, 6'h01}) begin errors++; $display("FAIL rst_restart got %b%b/%h want 01/01", game_over, disp_valid, disp_glyph); end
        answer = 2'd2; answer_valid = 1'b1;
        step();
        answer_valid = 1'b0;
        step();
        enable = 1'b0;
        step();
        checks++; if ({correct_led, disp_valid, score, lives} !== {2'b00, 8'd1, 3'd3}) begin errors++; $display("FAIL enable_drop got %b%b/%0d/%0d want 00/1/3", correct_led, disp_valid, score, lives); end
        for (int i = 0; i < 6; i++) begin step(); fc_cnt += int'(force_change); end
        checks++; if (fc_cnt != 0) begin errors++; $display("FAIL enable_drop_fc got %0d want 0", fc_cnt); end
        enable = 1'b1;
        steps(4);
        checks++; if ({disp_valid, disp_glyph} !== {1'b1, 6'h01}) begin errors++; $display("FAIL enable_resume got %b/%h want 1/01", disp_valid, disp_glyph); end
    endtask

    task automatic test_saturate();
        answer = 2'd2;
        for (int r = 0; r < 254; r++) begin
            answer_valid = 1'b1;
            step();
            answer_valid = 1'b0;
            steps(10);
        end
        checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d want 255", score); end
        answer_valid = 1'b1;
        step();
        answer_valid = 1'b0;
        step();
        checks++; if ({correct_led, score} !== {1'b1, 8'd255}) begin errors++; $display("FAIL sat_hold got %b/%0d want 1/255", correct_led, score); end
        steps(9);
        checks++; if ({disp_valid, score} !== {1'b1, 8'd255}) begin errors++; $display("FAIL sat_after got %b/%0d want 1/255", disp_valid, score); end
    endtask

    task automatic test_rst_mid_fb();
        int fc_cnt = 0;
        answer = 2'd2; answer_valid = 1'b1;
        step();
        answer_valid = 1'b0;
        steps(2);
        checks++; if (correct_led !== 1'b1) begin errors++; $display("FAIL rst_fb_pre got %b want 1", correct_led); end
        rst = 1'b1;
        step();
        checks++; if ({correct_led, force_change, score, lives} !== {2'b00, 8'd0, 3'd3}) begin errors++; $display("FAIL rst_fb got %b%b/%0d/%0d want 00/0/3", correct_led, force_change, score, lives); end
        for (int i = 0; i < 4; i++) begin step(); fc_cnt += int'(force_change); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); fc_cnt += int'(force_change); end
        checks++; if (fc_cnt != 0) begin errors++; $display("FAIL rst_fb_fc got %0d want 0", fc_cnt); end
    endtask

    initial begin
        mem[0] = 8'h81; mem[1] = 8'h42; mem[2] = 8'hC3; mem[3] = 8'h04;
        test_reset();
        test_fetch();
        test_timeout();
        test_correct();
        test_back_to_back();
        test_wrong();
        test_enable_drop();
        test_saturate();
        test_rst_mid_fb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
